// File: rtl/lif_neurons_axi4s_pkg.sv
// Shared widths, saturation bounds and helpers for the LIF neuron array.
package lif_neurons_axi4s_pkg;
   localparam int LANE_W = 16;
   localparam int ACC_W  = 18;
   localparam int REF_W  = 4;

   typedef logic signed [LANE_W-1:0] lane_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic        [REF_W-1:0]  ref_t;

   localparam acc_t SAT_MAX = 18'sd32767;
   localparam acc_t SAT_MIN = -18'sd32768;

   function automatic acc_t sext(input lane_t x);
      return {{(ACC_W-LANE_W){x[LANE_W-1]}}, x};
   endfunction

   function automatic lane_t sat_lane(input acc_t a);
      if (a > SAT_MAX) return SAT_MAX[LANE_W-1:0];
      if (a < SAT_MIN) return SAT_MIN[LANE_W-1:0];
      return a[LANE_W-1:0];
   endfunction
endpackage

// File: rtl/lif_neurons_axi4s_neuron.sv
// One leaky integrate-and-fire lane: membrane, leak, saturation, threshold, refractory.
module lif_neuron
   import lif_neurons_axi4s_pkg::*;
#(
   parameter lane_t THRESHOLD  = 16'sd1000,
   parameter int    LEAK_SHIFT = 4,
   parameter int    REFRACTORY = 2
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  en,
   input  logic  lane_vld,
   input  lane_t cur,
   output logic  spike
);
   lane_t v;
   ref_t  ref_cnt;
   acc_t  sum;
   lane_t sat;
   logic  in_ref;

   always_comb begin
      sum    = sext(v) - sext(v >>> LEAK_SHIFT) + (lane_vld ? sext(cur) : '0);
      sat    = sat_lane(sum);
      in_ref = (ref_cnt != '0);
      spike  = !in_ref && (sat >= THRESHOLD);
   end

   // State moves only on accepted beats, so a stalled stream does not leak.
   always_ff @(posedge clk) begin
      if (reset) begin
         v       <= '0;
         ref_cnt <= '0;
      end else if (en) begin
         if (in_ref) begin
            v       <= '0;
            ref_cnt <= ref_cnt - ref_t'(1);
         end else if (spike) begin
            v       <= '0;
            ref_cnt <= ref_t'(REFRACTORY);
         end else begin
            v       <= sat;
         end
      end
   end
endmodule

// File: rtl/lif_neurons_axi4s.sv
// AXI4-Stream wrapper: one timestep per accepted beat, registered spike vector out.
module lif_neurons_axi4s
   import lif_neurons_axi4s_pkg::*;
#(
   parameter int    NUM_NEURONS = 8,
   parameter lane_t THRESHOLD   = 16'sd1000,
   parameter int    LEAK_SHIFT  = 4,
   parameter int    REFRACTORY  = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_NEURONS*LANE_W-1:0] s_axis_tdata,
   input  logic [NUM_NEURONS-1:0]        s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic [NUM_NEURONS-1:0]        m_axis_tdata,
   output logic [15:0]                   m_axis_tstep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready
);
   logic [NUM_NEURONS-1:0] spikes;
   logic [15:0]            tstep_cnt;
   logic                   accept;

   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign accept        = (|s_axis_tvalid) && s_axis_tready;

   for (genvar i = 0; i < NUM_NEURONS; i++) begin : gen_lane
      lif_neuron #(
         .THRESHOLD (THRESHOLD),
         .LEAK_SHIFT(LEAK_SHIFT),
         .REFRACTORY(REFRACTORY)
      ) u_neuron (
         .clk     (clk),
         .reset   (reset),
         .en      (accept),
         .lane_vld(s_axis_tvalid[i]),
         .cur     (s_axis_tdata[LANE_W*i +: LANE_W]),
         .spike   (spikes[i])
      );
   end

   // Accept overrides drain so a same-cycle handshake reloads without a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tstep  <= '0;
         tstep_cnt     <= '0;
      end else if (accept) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= spikes;
         m_axis_tstep  <= tstep_cnt;
         tstep_cnt     <= tstep_cnt + 16'd1;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_lif_neurons_axi4s.sv
// Directed bench for lif_neurons_axi4s with hand-computed membrane/spike values.
module tb_lif_neurons_axi4s;
   logic         clk = 0;
   logic         reset;
   logic [127:0] s_axis_tdata;
   logic [7:0]   s_axis_tvalid;
   logic         s_axis_tready;
   logic [7:0]   m_axis_tdata;
   logic [15:0]  m_axis_tstep;
   logic         m_axis_tvalid;
   logic         m_axis_tready;

   int n_checks = 0;
   int n_pass   = 0;

   lif_neurons_axi4s dut (
      .clk(clk), .reset(reset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tstep(m_axis_tstep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready)
   );

   always #5 clk = ~clk;

   wire signed [15:0] v0 = dut.gen_lane[0].u_neuron.v;
   wire signed [15:0] v2 = dut.gen_lane[2].u_neuron.v;
   wire signed [15:0] v3 = dut.gen_lane[3].u_neuron.v;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic signed [15:0] val);
      s_axis_tdata[16*i +: 16] = val;
   endtask

   task automatic beat(input logic [7:0] mask);
      s_axis_tvalid = mask;
      tick();
      s_axis_tvalid = '0;
   endtask

   task automatic test_reset();
      reset = 1;
      tick(); tick();
      n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); else n_pass++;
      n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL rst_tdata got %h exp 00", m_axis_tdata); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd0) $display("FAIL rst_tstep got %0d exp 0", m_axis_tstep); else n_pass++;
      n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL rst_tready got %b exp 1", s_axis_tready); else n_pass++;
      reset = 0;
      tick();
      n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL post_rst_tready got %b exp 1", s_axis_tready); else n_pass++;
   endtask

   task automatic test_zero_beat();
      s_axis_tdata = '0;
      beat(8'hFF);
      n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL zero_tvalid got %b exp 1", m_axis_tvalid); else n_pass++;
      n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL zero_spk got %h exp 00", m_axis_tdata); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd0) $display("FAIL zero_tstep got %0d exp 0", m_axis_tstep); else n_pass++;
      // no lane valid: nothing accepted, output drains
      tick();
      n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL idle_tvalid got %b exp 0", m_axis_tvalid); else n_pass++;
   endtask

   task automatic test_integrate();
      set_lane(0, 16'sd600);
      beat(8'h01);
      n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL int1_spk got %h exp 00", m_axis_tdata); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd1) $display("FAIL int1_tstep got %0d exp 1", m_axis_tstep); else n_pass++;
      n_checks++; if (v0 !== 16'sd600) $display("FAIL int1_v0 got %0d exp 600", v0); else n_pass++;
      beat(8'h01);
      n_checks++; if (m_axis_tdata !== 8'h01) $display("FAIL int2_spk got %h exp 01", m_axis_tdata); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd2) $display("FAIL int2_tstep got %0d exp 2", m_axis_tstep); else n_pass++;
      n_checks++; if (v0 !== 16'sd0) $display("FAIL int2_v0 got %0d exp 0", v0); else n_pass++;
   endtask

   task automatic test_refractory();
      logic [7:0] exp_spk [3] = '{8'h00, 8'h00, 8'h01};
      set_lane(0, 16'sd2000);
      for (int k = 0; k < 3; k++) begin
         beat(8'h01);
         n_checks++; if (m_axis_tdata !== exp_spk[k]) $display("FAIL refr%0d_spk got %h exp %h", k, m_axis_tdata, exp_spk[k]); else n_pass++;
         n_checks++; if (m_axis_tstep !== 16'(3 + k)) $display("FAIL refr%0d_tstep got %0d exp %0d", k, m_axis_tstep, 3 + k); else n_pass++;
         n_checks++; if (v0 !== 16'sd0) $display("FAIL refr%0d_v0 got %0d exp 0", k, v0); else n_pass++;
      end
   endtask

   task automatic test_saturation();
      s_axis_tdata = '0;
      set_lane(2, -16'sd32768);
      for (int k = 0; k < 2; k++) begin
         beat(8'h04);
         n_checks++; if (v2 !== -16'sd32768) $display("FAIL sat%0d_v2 got %0d exp -32768", k, v2); else n_pass++;
         n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL sat%0d_spk got %h exp 00", k, m_axis_tdata); else n_pass++;
         n_checks++; if (m_axis_tstep !== 16'(6 + k)) $display("FAIL sat%0d_tstep got %0d exp %0d", k, m_axis_tstep, 6 + k); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      tick();
      n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL bp_drain got %b exp 0", m_axis_tvalid); else n_pass++;
      m_axis_tready = 0;
      s_axis_tdata  = '0;
      set_lane(3, 16'sd500);
      beat(8'h08);
      n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL bp_tvalid got %b exp 1", m_axis_tvalid); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd8) $display("FAIL bp_tstep got %0d exp 8", m_axis_tstep); else n_pass++;
      n_checks++; if (v3 !== 16'sd500) $display("FAIL bp_v3 got %0d exp 500", v3); else n_pass++;
      n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL bp_tready got %b exp 0", s_axis_tready); else n_pass++;
      set_lane(3, 16'sd700);
      s_axis_tvalid = 8'h08;
      tick(); tick();
      n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL hold_tvalid got %b exp 1", m_axis_tvalid); else n_pass++;
      n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL hold_spk got %h exp 00", m_axis_tdata); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd8) $display("FAIL hold_tstep got %0d exp 8", m_axis_tstep); else n_pass++;
      n_checks++; if (v3 !== 16'sd500) $display("FAIL hold_v3 got %0d exp 500", v3); else n_pass++;
      // release: held beat leaves and queued beat enters on the same edge
      m_axis_tready = 1;
      tick();
      s_axis_tvalid = '0;
      n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL rel_tvalid got %b exp 1", m_axis_tvalid); else n_pass++;
      n_checks++; if (m_axis_tdata !== 8'h08) $display("FAIL rel_spk got %h exp 08", m_axis_tdata); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd9) $display("FAIL rel_tstep got %0d exp 9", m_axis_tstep); else n_pass++;
      n_checks++; if (v3 !== 16'sd0) $display("FAIL rel_v3 got %0d exp 0", v3); else n_pass++;
      tick();
   endtask

   task automatic test_reset_stall();
      m_axis_tready = 0;
      s_axis_tdata  = '0;
      set_lane(0, 16'sd100);
      beat(8'h01);
      tick();
      n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL rs_pend got %b exp 1", m_axis_tvalid); else n_pass++;
      reset = 1;
      tick();
      n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rs_tvalid got %b exp 0", m_axis_tvalid); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd0) $display("FAIL rs_tstep got %0d exp 0", m_axis_tstep); else n_pass++;
      n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL rs_tready got %b exp 1", s_axis_tready); else n_pass++;
      reset = 0;
      m_axis_tready = 1;
      tick();
      n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rs_stale got %b exp 0", m_axis_tvalid); else n_pass++;
      set_lane(0, 16'sd600);
      beat(8'h01);
      n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL rs_new_tvalid got %b exp 1", m_axis_tvalid); else n_pass++;
      n_checks++; if (m_axis_tdata !== 8'h00) $display("FAIL rs_new_spk got %h exp 00", m_axis_tdata); else n_pass++;
      n_checks++; if (m_axis_tstep !== 16'd0) $display("FAIL rs_new_tstep got %0d exp 0", m_axis_tstep); else n_pass++;
      n_checks++; if (v0 !== 16'sd600) $display("FAIL rs_new_v0 got %0d exp 600", v0); else n_pass++;
   endtask

   task automatic test_back_to_back();
      // lane 4 = 400: v 400, 775, 1127 -> spike, then refractory
      logic [7:0] exp_spk [4] = '{8'h00, 8'h00, 8'h10, 8'h00};
      s_axis_tdata = '0;
      set_lane(4, 16'sd400);
      s_axis_tvalid = 8'h10;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL b2b%0d_tvalid got %b exp 1", k, m_axis_tvalid); else n_pass++;
         n_checks++; if (m_axis_tdata !== exp_spk[k]) $display("FAIL b2b%0d_spk got %h exp %h", k, m_axis_tdata, exp_spk[k]); else n_pass++;
         n_checks++; if (m_axis_tstep !== 16'(1 + k)) $display("FAIL b2b%0d_tstep got %0d exp %0d", k, m_axis_tstep, 1 + k); else n_pass++;
      end
      s_axis_tvalid = '0;
      tick();
   endtask

   initial begin
      reset = 1;
      s_axis_tdata  = '0;
      s_axis_tvalid = '0;
      m_axis_tready = 1;
      test_reset();
      test_zero_beat();
      test_integrate();
      test_refractory();
      test_saturation();
      test_backpressure();
      test_reset_stall();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/lif_neurons_axi4s.md
LIF_NEURONS_AXI4S -- requirements
Module: lif_neurons_axi4s

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 8, number of neuron lanes; each lane takes one 16-bit slice of the 128-bit input.
REQ-002 SHALL have parameter THRESHOLD, default 16'sd1000, signed firing threshold.
REQ-003 SHALL have parameter LEAK_SHIFT, default 4, leak as an arithmetic right-shift amount, range 1..15.
REQ-004 SHALL have parameter REFRACTORY, default 2, timesteps a lane stays silent after a spike, range 0..15.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 s_axis_tdata  input  128  packed signed currents; lane i = bits [16*i+15:16*i].
REQ-008 s_axis_tvalid  input  NUM_NEURONS  per-lane valid from the upstream MAC array.
REQ-009 s_axis_tready  output  1  beat acceptance ready.
REQ-010 m_axis_tdata  output  NUM_NEURONS  spike vector; bit i = lane i fired this timestep.
REQ-011 m_axis_tstep  output  16  timestep index of the current output beat.
REQ-012 m_axis_tvalid  output  1  output beat valid.
REQ-013 m_axis_tready  input  1  downstream ready.

Function
REQ-014 An input beat (one timestep) SHALL be accepted when (|s_axis_tvalid) && s_axis_tready.
REQ-015 s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready (single output register, no extra buffering).
REQ-016 Per accepted beat, each lane SHALL compute sum = v - (v >>> LEAK_SHIFT) + (s_axis_tvalid[i] ? in[i] : 0) in 18-bit signed arithmetic, then saturate to [-32768, 32767].
REQ-017 A lane with refractory count > 0 SHALL instead set v = 0, decrement the count, and not spike; its input is discarded.
REQ-018 Otherwise, if the saturated sum >= THRESHOLD, the lane SHALL spike, set v = 0 and load refractory count = REFRACTORY; if not, v = saturated sum.
REQ-019 Membrane and refractory state SHALL change only on accepted beats; no leak is applied while idle or stalled.
REQ-020 The output beat SHALL appear with m_axis_tvalid = 1 on the cycle after acceptance (latency 1) and carry the spike vector and the timestep.
REQ-021 m_axis_tvalid SHALL be held, with m_axis_tdata and m_axis_tstep stable, until m_axis_tready = 1.
REQ-022 Accept and output handshakes in the same cycle SHALL replace the output register with the new beat without a bubble.
REQ-023 The timestep counter SHALL increment by 1 per accepted beat and wrap 16'hFFFF -> 0; the first beat after reset SHALL carry tstep 0.
REQ-024 s_axis_tvalid = 0 on all lanes SHALL accept nothing, even when s_axis_tready = 1.

Reset
REQ-025 While reset = 1: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tstep = 0, all membranes = 0, all refractory counts = 0, timestep counter = 0.
REQ-026 s_axis_tready SHALL read 1 during and after reset, following REQ-015.
REQ-027 Reset asserted mid-stall SHALL drop the pending output beat; no beat is emitted after reset until a new input beat is accepted.

Structure
REQ-028 A shared package SHALL hold the lane width (16), the accumulator width (18), the saturation bounds, and the refractory-counter width (4).
REQ-029 One sub-module, lif_neuron, SHALL hold the per-lane membrane, leak, saturation, threshold and refractory logic, instantiated NUM_NEURONS times by generate.
REQ-030 The top level SHALL own the handshake, the output register and the timestep counter.

Verification
REQ-031 Reset -> outputs all 0, s_axis_tready = 1; then one beat of all lanes = 0 -> spikes 8'h00, tstep 0.
REQ-032 Lane 0 = 600 for two beats -> beat 1: v = 600, no spike; beat 2: v = 600 - 37 + 600 = 1163 -> spike bit0 = 1, v = 0.
REQ-033 After a lane-0 spike, lane 0 = 2000 for three beats -> no spike on beats 1 and 2 (v held 0), spike on beat 3.
REQ-034 Lane 2 = -32768 for two beats -> v = -32768, then -30720 - 32768 saturates to -32768; no spike.
REQ-035 Backpressure: m_axis_tready = 0 with an output beat pending -> s_axis_tready = 0, the next beat is not consumed, and membranes are unchanged; m_axis_tready = 1 -> the held beat transfers and the queued beat is accepted the same cycle (REQ-022).
REQ-036 Reset pulse during a stall, then a lane-0 = 600 beat -> v = 600 (no residue), tstep 0, no stale output beat.
